// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
// Mask codes follow the RISC-V load/store funct3 encoding.
package cache_pkg;

  localparam int DEF_INDEX_BITS = 4;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RMISS,
    WRITE,
    WDONE
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: load extract with sign/zero extension,
// store lane shift with byte-enable generation.
module lsu_align
  import cache_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  mask,
  input  logic [31:0] line,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data,
  output logic [3:0]  st_be
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = line >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? line[31:16] : line[15:0];
    case (mask)
      MASK_B:  ld_data = {{24{b[7]}}, b};
      MASK_BU: ld_data = {24'h0, b};
      MASK_H:  ld_data = {{16{h[15]}}, h};
      MASK_HU: ld_data = {16'h0, h};
      default: ld_data = line;
    endcase
  end

  always_comb begin
    case (mask)
      MASK_B, MASK_BU: begin
        st_data = {24'h0, wdata[7:0]} << {off, 3'b000};
        st_be   = 4'b0001 << off;
      end
      MASK_H, MASK_HU: begin
        st_data = off[1] ? {wdata[15:0], 16'h0}
                         : {16'h0, wdata[15:0]};
        st_be   = off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = wdata;
        st_be   = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// between the core memory stage and a req/ack word bus.
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  mask,
  input  logic        rd_en,
  input  logic        wr_en,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [INDEX_BITS-1:0] idx, fidx;
  logic [TAG_W-1:0]      tag, ftag;
  logic                  hit;
  logic [31:0]           ld_data, st_data;
  logic [3:0]            st_be;

  assign idx  = addr[INDEX_BITS+1:2];
  assign tag  = addr[31:INDEX_BITS+2];
  assign fidx = mem_addr[INDEX_BITS+1:2];
  assign ftag = mem_addr[31:INDEX_BITS+2];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);

  lsu_align u_align (
    .off     (addr[1:0]),
    .mask    (mask),
    .line    (data_q[idx]),
    .wdata   (wdata),
    .ld_data (ld_data),
    .st_data (st_data),
    .st_be   (st_be)
  );

  assign rdata   = rd_en ? ld_data : 32'h0;
  assign mem_req = (state_q == RMISS) || (state_q == WRITE);
  assign mem_we  = (state_q == WRITE);

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          stall   = 1'b1;
          state_d = WRITE;
        end else if (rd_en && !hit) begin
          stall   = 1'b1;
          state_d = RMISS;
        end
      end
      RMISS: begin
        stall = 1'b1;
        if (mem_ack) state_d = IDLE;
      end
      WRITE: begin
        stall = 1'b1;
        if (mem_ack) state_d = WDONE;
      end
      WDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'h0;
    end else begin
      state_q <= state_d;
      // Bus fields freeze here and stay stable until the ack.
      if (state_q == IDLE && state_d != IDLE) begin
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= wr_en ? st_data : 32'h0;
        mem_be    <= wr_en ? st_be : 4'h0;
      end
      if (state_q == RMISS && mem_ack) valid_q[fidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == IDLE && wr_en && hit) begin
        for (int i = 0; i < 4; i++) begin
          if (st_be[i]) data_q[idx][8*i +: 8] <= st_data[8*i +: 8];
        end
      end
      if (state_q == RMISS && mem_ack) begin
        data_q[fidx] <= mem_rdata;
        tag_q[fidx]  <= ftag;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: vector table plus reset-abort sequence,
// with a behavioural word memory answering the req/ack bus.
module tb_dcache_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata;
  logic [2:0]  mask;
  logic        rd_en, wr_en;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;
  int cnt      = 0;
  logic force_ack = 1'b0;

  logic [31:0] mem [logic [31:0]];

  dcache_ctrl #(.INDEX_BITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .mask      (mask),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .rdata     (rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Memory responder: ack in the lat-th request cycle.
  always begin
    @(posedge clk);
    #1;
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      cnt       = 0;
    end else if (mem_req) begin
      cnt++;
      if (cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_we ? 32'h0 : mem_rd(mem_addr);
        if (mem_we) begin
          logic [31:0] w;
          w = mem_rd(mem_addr);
          for (int i = 0; i < 4; i++)
            if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
          mem[mem_addr] = w;
        end
        cnt = 0;
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      mem_ack = 1'b0;
      cnt     = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_stalls;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_mem;
    logic [31:0] exp_maddr;
    logic        exp_mwe;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwd;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic run_vec(input int n, input vec_t v);
    int          stalls;
    bit          done, got;
    logic [31:0] rd_v, ma, mwd;
    logic        mwe;
    logic [3:0]  mbe;
    stalls = 0; done = 0; got = 0;
    rd_v = 0; ma = 0; mwd = 0; mwe = 0; mbe = 0;
    lat   = v.lat;
    rd_en = v.rd;
    wr_en = v.wr;
    mask  = v.mask;
    addr  = v.addr;
    wdata = v.wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_req && !got) begin
        got = 1; ma = mem_addr; mwe = mem_we;
        mbe = mem_be; mwd = mem_wdata;
      end
      if (!stall) begin
        done = 1;
        rd_v = rdata;
      end else begin
        stalls++;
        @(posedge clk);
        #2;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL v%0d timeout: stall still high", n);
    end else begin
      chk($sformatf("v%0d stalls", n), stalls, v.exp_stalls);
      if (v.chk_rd) chk($sformatf("v%0d rdata", n), rd_v, v.exp_rd);
      if (v.chk_mem) begin
        chk($sformatf("v%0d mem_req", n), {31'h0, got}, 32'h1);
        chk($sformatf("v%0d mem_addr", n), ma, v.exp_maddr);
        chk($sformatf("v%0d mem_we", n), {31'h0, mwe}, {31'h0, v.exp_mwe});
        if (v.exp_mwe) begin
          chk($sformatf("v%0d mem_be", n), {28'h0, mbe}, {28'h0, v.exp_be});
          chk($sformatf("v%0d mem_wdata", n), mwd, v.exp_mwd);
        end
      end
    end
    @(posedge clk);
    #2;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1,0,MASK_W, 32'h40, 0,          2,3,1,32'hDEADBEEF,1,32'h40, 0,4'h0,32'h0};
    vecs[1]  = '{1,0,MASK_W, 32'h40, 0,          2,0,1,32'hDEADBEEF,0,32'h0,  0,4'h0,32'h0};
    vecs[2]  = '{0,0,MASK_W, 32'h40, 0,          2,0,1,32'h0,       0,32'h0,  0,4'h0,32'h0};
    vecs[3]  = '{0,1,MASK_W, 32'h40, 32'h807060F0,1,2,0,32'h0,      1,32'h40, 1,4'hF,32'h807060F0};
    vecs[4]  = '{1,0,MASK_W, 32'h40, 0,          1,0,1,32'h807060F0,0,32'h0,  0,4'h0,32'h0};
    vecs[5]  = '{1,0,MASK_B, 32'h43, 0,          1,0,1,32'hFFFFFF80,0,32'h0,  0,4'h0,32'h0};
    vecs[6]  = '{1,0,MASK_BU,32'h43, 0,          1,0,1,32'h00000080,0,32'h0,  0,4'h0,32'h0};
    vecs[7]  = '{1,0,MASK_H, 32'h42, 0,          1,0,1,32'hFFFF8070,0,32'h0,  0,4'h0,32'h0};
    vecs[8]  = '{1,0,MASK_HU,32'h42, 0,          1,0,1,32'h00008070,0,32'h0,  0,4'h0,32'h0};
    vecs[9]  = '{1,0,MASK_B, 32'h40, 0,          1,0,1,32'hFFFFFFF0,0,32'h0,  0,4'h0,32'h0};
    vecs[10] = '{1,0,MASK_H, 32'h40, 0,          1,0,1,32'h000060F0,0,32'h0,  0,4'h0,32'h0};
    vecs[11] = '{0,1,MASK_B, 32'h41, 32'h000000AB,3,4,0,32'h0,      1,32'h40, 1,4'h2,32'h0000AB00};
    vecs[12] = '{1,0,MASK_W, 32'h40, 0,          1,0,1,32'h8070ABF0,0,32'h0,  0,4'h0,32'h0};
    vecs[13] = '{1,1,MASK_H, 32'h42, 32'h00001234,2,3,0,32'h0,      1,32'h40, 1,4'hC,32'h12340000};
    vecs[14] = '{1,0,MASK_W, 32'h43, 0,          1,0,1,32'h1234ABF0,0,32'h0,  0,4'h0,32'h0};
    vecs[15] = '{1,0,MASK_BU,32'h42, 0,          1,0,1,32'h00000034,0,32'h0,  0,4'h0,32'h0};
    vecs[16] = '{0,1,MASK_W, 32'h100,32'h12345678,2,3,0,32'h0,      1,32'h100,1,4'hF,32'h12345678};
    vecs[17] = '{1,0,MASK_W, 32'h40, 0,          1,0,1,32'h1234ABF0,0,32'h0,  0,4'h0,32'h0};
    vecs[18] = '{1,0,MASK_W, 32'h100,0,          2,3,1,32'h12345678,1,32'h100,0,4'h0,32'h0};
    vecs[19] = '{1,0,MASK_W, 32'h40, 0,          1,2,1,32'h1234ABF0,1,32'h40, 0,4'h0,32'h0};
    vecs[20] = '{1,0,MASK_W, 32'h80, 0,          1,2,1,32'h55AA55AA,1,32'h80, 0,4'h0,32'h0};
    vecs[21] = '{1,0,MASK_W, 32'h40, 0,          1,2,1,32'h1234ABF0,1,32'h40, 0,4'h0,32'h0};
    vecs[22] = '{1,0,MASK_W, 32'h40, 0,          1,0,1,32'h1234ABF0,0,32'h0,  0,4'h0,32'h0};

    mem[32'h40] = 32'hDEADBEEF;
    mem[32'h80] = 32'h55AA55AA;
    mem[32'h44] = 32'h13579BDF;

    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    addr = 32'h0; wdata = 32'h0; mask = MASK_W;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst stall", {31'h0, stall}, 32'h0);
    chk("rst mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst rdata", rdata, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset in the 2nd RMISS cycle of a slow fill, then a stray ack.
    lat = 5; rd_en = 1'b1; mask = MASK_W; addr = 32'h44;
    @(negedge clk);
    chk("abort detect stall", {31'h0, stall}, 32'h1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    chk("abort req before", {31'h0, mem_req}, 32'h1);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("abort req after", {31'h0, mem_req}, 32'h0);
    chk("abort stall after", {31'h0, stall}, 32'h0);
    force_ack = 1'b1;
    @(posedge clk); #2;
    force_ack = 1'b0;
    @(negedge clk);
    chk("late ack req", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #2;
    run_vec(100, '{1,0,MASK_W,32'h44,0,1,2,1,32'h13579BDF,1,32'h44,0,4'h0,32'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache that answers the core's load/store port: address, store data, access-size mask, read/write enables in; load data and a stall out. It sits between the single-cycle core's memory stage and main memory. On the downstream side it acts as an initiator over a req/ack word bus. Load hits complete in the same cycle; misses and all stores hold the core with `stall` until memory acknowledges.

## Interface
- INDEX_BITS, 4: number of lines is 2^INDEX_BITS; each line holds one 32-bit word.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- addr  in  32  byte address from the core's ALU.
- wdata  in  32  store data, right-aligned.
- mask  in  3  access type, funct3 encoding: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
- rd_en  in  1  load request.
- wr_en  in  1  store request.
- rdata  out  32  load result, sign- or zero-extended per `mask`.
- stall  out  1  core must hold its PC and request inputs.
- mem_req  out  1  downstream transaction valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word-aligned address (bits [1:0] = 0).
- mem_wdata  out  32  lane-positioned store data.
- mem_be  out  4  byte enables for writes.
- mem_rdata  in  32  read data, valid with `mem_ack`.
- mem_ack  in  1  transaction complete.

## Operation
- Address split: offset [1:0], index [INDEX_BITS+1:2], tag [31:INDEX_BITS+2]. Offset bits below the access size are ignored (half uses addr[1], word uses none).
- States: IDLE, RMISS, WRITE, WDONE.
- IDLE with rd_en and hit: `rdata` comes from the line combinationally; stall=0; state stays IDLE.
- IDLE with rd_en and miss: stall=1; the word address is latched; next state RMISS.
- IDLE with wr_en: stall=1; address, lane-shifted data and byte enables are latched; next state WRITE. On a hit, the line is byte-merged in the same edge. A miss leaves the cache unchanged.
- rd_en and wr_en both high: treated as a store.
- RMISS: mem_req=1, mem_we=0, stall=1. On mem_ack, the line is written with mem_rdata, valid=1, tag updated, and next state is IDLE. The core's request is still held, so it now hits.
- WRITE: mem_req=1, mem_we=1, stall=1. On mem_ack, next state is WDONE.
- WDONE: stall=0 for exactly one cycle so the core retires the store; next state IDLE. A new request is not evaluated until IDLE.
- Neither enable in IDLE: stall=0, no action.

## Timing
- Reset values: state IDLE, all valid bits 0, mem_req 0, mem_we 0, stall 0, mem_addr/mem_wdata/mem_be 0. rdata is a don't-care when rd_en=0 and is driven 0.
- Reset during RMISS or WRITE aborts immediately: mem_req drops on the next cycle. A mem_ack arriving afterwards is ignored.
- Downstream rule: mem_req and all mem_* outputs stay stable from assertion until the cycle mem_ack is sampled high. mem_ack is accepted in the first mem_req cycle, so minimum occupancy is 1 cycle.
- Load miss, ack in the N-th RMISS cycle: stall is high for N+1 cycles, and the hit is returned in cycle N+1 after detection.
- Store, ack in the N-th WRITE cycle: stall is high for N+1 cycles, then WDONE cycle with stall=0.
- A fill replaces the old line unconditionally (write-through means no eviction writeback).

## Structure
- Package `cache_pkg`: state enum, mask encoding constants (MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU), default INDEX_BITS.
- Sub-module `lsu_align` (combinational): load lane extract plus sign/zero extension, and store lane shift plus byte-enable generation. It is shared by the hit merge and the mem_wdata/mem_be path.
- Tag, valid and data arrays are flops, cleared via valid only.

## Test plan
- After reset, load word at 0x0000_0040 -> stall for 1 + memory latency cycles, mem_addr=0x40, mem_we=0. Memory returns 0xDEAD_BEEF -> next cycle rdata=0xDEAD_BEEF, stall=0. A repeat load hits with stall=0.
- With 0x40 cached as 0x8070_60F0, load byte at 0x43 -> rdata 0xFFFF_FF80. Load byte-unsigned -> 0x0000_0080. Load half at 0x42 -> 0xFFFF_8070. Half-unsigned -> 0x0000_8070.
- Store byte 0xAB to 0x41 (hit) -> mem_be=0010, mem_wdata[15:8]=0xAB, then WDONE. A following load word reads 0x8070_ABF0.
- Store to uncached 0x100, then load 0x100 -> the store does not allocate, so the load misses.
- Aliasing with INDEX_BITS=4: load 0x40, then load 0x80 (same index) -> second is a miss, and reloading 0x40 misses again.
- Assert reset in the 2nd cycle of an RMISS with a 5-cycle memory -> mem_req=0 the next cycle, late ack ignored, the line stays invalid.
